nibble_serial_sub: RTL
======================

// Module: nibble_serial_sub
// PURPOSE
//   Multi-cycle subtractor, the subtract-direction counterpart of the 4-bit CLA adder.
//   Computes diff = a - b - b_in, processing 4 bits per clock with a ripple borrow between nibbles.
//   Reports borrow, signed overflow and zero flags.
//   Used by the ALU / datapath labs where area matters more than latency.
//   Valid/ready handshake on both input and output sides.
// PARAMETERS
//   WIDTH    32   operand width in bits; must be a multiple of 4 (>= 4)
//   NIBBLES  WIDTH/4  derived localparam: number of nibble steps; not overridable
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous reset, active-high
//   in_valid    in   1      operand request valid
//   in_ready    out  1      block can accept operands
//   a           in   WIDTH  minuend
//   b           in   WIDTH  subtrahend
//   b_in        in   1      borrow in (1 = subtract one more)
//   out_valid   out  1      result valid
//   out_ready   in   1      consumer accepts result
//   diff        out  WIDTH  a - b - b_in, modulo 2^WIDTH
//   borrow_out  out  1      final borrow: 1 iff unsigned a < b + b_in
//   ovf         out  1      signed two's-complement overflow
//   zero        out  1      diff == 0
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; diff=0; borrow_out=0; ovf=0; zero=0.
//     Internal operand registers and nibble counter are cleared.
//   Reset is asynchronous and applies in every state. An in-flight operation is discarded, with no partial output.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1, out_valid=0.
//     On in_valid & in_ready at an edge: latch a, b, b_in; cnt<=0; go to RUN.
//   RUN: in_ready=0. Each edge processes nibble k=cnt (bits 4k+3:4k):
//     {c, d} = a_k + ~b_k + !bor, a 5-bit sum; bor <= !c; diff[4k+3:4k] <= d; cnt <= cnt+1.
//     On cnt==NIBBLES-1, after that nibble is written, go to DONE.
//   DONE: out_valid=1. diff, borrow_out (= final bor), ovf and zero are stable while out_valid=1.
//     ovf  = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched a and b.
//     zero = ~|diff.
//     On out_valid & out_ready at an edge: go to IDLE; out_valid drops; in_ready rises the next cycle.
//   Latency: out_valid rises NIBBLES edges after the accept edge (8 for WIDTH=32).
//     Throughput is one op per NIBBLES+2 cycles; there is no same-cycle result/accept overlap.
//   in_valid, a, b and b_in are ignored while in_ready=0. Inputs need only be stable at the accept edge.
//   out_ready is ignored outside DONE. out_ready held high in DONE: handshake completes on the first DONE cycle.
//   Flag/diff registers keep their last values after the handshake. Consumers must qualify them with out_valid.
//   WIDTH=4: a single RUN cycle; the same rules apply.
// TESTING (WIDTH=32, out_ready=1 unless stated)
//   T1 a=0x00000005 b=0x00000003 b_in=0 -> diff=0x00000002 borrow=0 ovf=0 zero=0.
//      out_valid high exactly 8 cycles after accept.
//   T2 a=0x00000000 b=0x00000001 b_in=0 -> diff=0xFFFFFFFF borrow=1 ovf=0 zero=0.
//   T3 a=0x80000000 b=0x00000001 -> diff=0x7FFFFFFF borrow=0 ovf=1.
//      Also a=0x7FFFFFFF b=0xFFFFFFFF -> diff=0x80000000 ovf=1 borrow=1.
//   T4 a=b=0x12345678 b_in=0 -> diff=0 zero=1 borrow=0.
//      Same operands with b_in=1 -> diff=0xFFFFFFFF borrow=1 zero=0.
//   T5 Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands.
//      -> out_valid and outputs held, in_ready=0, new operands not taken.
//      Raise out_ready -> in_ready=1 the next cycle.
//   T6 Assert reset 3 cycles into RUN -> all outputs go to reset values immediately (async).
//      After release, in_ready=1 and a fresh op (T1 operands) gives the T1 result.
//   Random: 10k ops vs reference model (a - b - b_in), with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: diff = a - b - b_in, one nibble per clock with a ripple
// borrow. WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             bor_q, a_msb, b_msb;
    logic             borrow_q, ovf_q, zero_q;
    logic [CNT_W-1:0] cnt;

    logic             accept, last;
    logic [4:0]       nib_sum;
    logic [WIDTH-1:0] diff_step;

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; ready never depends on valid, and valid holds until the transfer.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CNT_W'(NIBBLES - 1));

    // Operands shift right one nibble per step, so the active nibble is always
    // bits [3:0]; results enter diff from the top and land aligned after the last step.
    assign nib_sum   = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, ~bor_q};
    assign diff_step = (diff_q >> 4) | (WIDTH'(nib_sum[3:0]) << (WIDTH - 4));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bor_q    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            cnt      <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                bor_q <= b_in;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            a_q    <= a_q >> 4;
            b_q    <= b_q >> 4;
            diff_q <= diff_step;
            bor_q  <= ~nib_sum[4];
            cnt    <= cnt + 1'b1;
            // Flags are captured with the top nibble so they stay frozen through DONE.
            if (last) begin
                borrow_q <= ~nib_sum[4];
                ovf_q    <= (a_msb != b_msb) & (nib_sum[3] != a_msb);
                zero_q   <= ~|diff_step;
            end
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;
    assign zero       = zero_q;

endmodule
